// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - byte/half/word store unit merging sub-word stores into a word-only memory
//
// Accepts one store request at a time from the MEM stage. Aligned word stores
// are written straight through. Byte and halfword stores read the containing
// word, splice the addressed lane in little-endian order, and write it back.
// Misaligned or illegal-size requests finish with an error response and
// generate no memory traffic.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-low reset
//   req_valid_i/ready_o  store request handshake
//   req_addr_i           byte address
//   req_data_i           store data (byte [7:0], half [15:0], word full)
//   req_size_i           00 byte, 01 half, 10 word, 11 illegal
//   done_o, err_o        one-cycle completion pulse and its error flag
//   mem_req_o, mem_we_o  memory request and direction (1 = write)
//   mem_addr_o           word-aligned memory address
//   mem_wdata_o          memory write data
//   mem_gnt_i            memory accepted the current request
//   mem_rvalid_i         read data valid
//   mem_rdata_i          read data
module store_merge_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [1:0]        req_size_i,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [15:0]       data_q,  data_d;   // only sub-word stores need the data later
    logic [1:0]        size_q,  size_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic              err_q,   err_d;

    logic              misalign;
    logic [DATA_W-1:0] merged;

    assign misalign = (req_size_i == 2'b11)
                    | ((req_size_i == SZ_HALF) & req_addr_i[0])
                    | ((req_size_i == SZ_WORD) & (|req_addr_i[1:0]));

    // Splice the latched store data into the word returned by the read.
    always_comb begin
        merged = mem_rdata_i;
        if (size_q == SZ_BYTE) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = data_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        merge_d = merge_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                // req_ready_o is high whenever we sit in IDLE out of reset
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    data_d = req_data_i[15:0];
                    size_d = req_size_i;
                    err_d  = misalign;
                    if (misalign) begin
                        state_d = S_RESP;
                    end else if (req_size_i == SZ_WORD) begin
                        merge_d = req_data_i;
                        state_d = S_WR_REQ;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid_i) begin
                    merge_d = merged;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            merge_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            merge_q <= merge_d;
            err_q   <= err_d;
        end
    end

    // rst_i gates ready so nothing is offered while reset is held.
    assign req_ready_o = rst_i & (state_q == S_IDLE);
    assign mem_req_o   = (state_q == S_RD_REQ) | (state_q == S_WR_REQ);
    assign mem_we_o    = (state_q == S_WR_REQ);
    assign mem_addr_o  = (state_q != S_IDLE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata_o = (state_q == S_WR_REQ) ? merge_q : '0;
    assign done_o      = (state_q == S_RESP);
    assign err_o       = (state_q == S_RESP) & err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - scoreboard testbench for store_merge_unit
module tb_store_merge_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic [1:0]  req_size_i;
    logic        done_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    store_merge_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .req_size_i   (req_size_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic       err;
        logic [7:0] lat;
    } rsp_t;

    wr_t  exp_wr[$];
    wr_t  obs_wr[$];
    rsp_t exp_rsp[$];
    rsp_t obs_rsp[$];

    logic [31:0] mem [logic [31:0]];

    int n_cmp  = 0;
    int n_fail = 0;

    int          n_rd_obs;
    logic [31:0] rd_addr_obs;
    bit          any_req;
    bit          unstable;
    bit          ready_bad;
    bit          ready_at_acc;

    // Drives one request and plays the memory with the given stall counts.
    // Observed writes and the response go to obs_wr / obs_rsp; k counts cycles
    // after the accepting edge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input int rd_gd, input int wr_gd, input int rv_d, input bit busy_req);
        int          ph_wait;
        int          rv_wait;
        bit          rd_pend;
        bit          done;
        bit          prev_req;
        logic [31:0] rd_a;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        logic        prev_we;
        n_rd_obs = 0; any_req = 0; unstable = 0; ready_bad = 0;
        ph_wait = 0; rv_wait = 0; rd_pend = 0; done = 0; prev_req = 0;
        rd_a = '0; prev_addr = '0; prev_wdata = '0; prev_we = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_addr_i = a; req_data_i = d; req_size_i = sz;
        ready_at_acc = req_ready_o;
        @(posedge clk_i); #1;
        req_valid_i = busy_req;
        req_addr_i  = 32'h0000_0080; req_data_i = 32'h9999_9999; req_size_i = 2'b10;
        for (int k = 1; k <= 40 && !done; k++) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h5A5A_5A5A;
            if (rd_pend) begin
                if (rv_wait >= rv_d) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = mem[rd_a]; rd_pend = 0;
                end else begin
                    rv_wait++;
                end
            end
            if (mem_req_o) begin
                any_req = 1;
                if (prev_req && (mem_addr_o !== prev_addr || mem_we_o !== prev_we ||
                                 mem_wdata_o !== prev_wdata)) unstable = 1;
                if (ph_wait >= (mem_we_o ? wr_gd : rd_gd)) begin
                    mem_gnt_i = 1'b1; ph_wait = 0;
                    if (mem_we_o) begin
                        obs_wr.push_back(wr_t'{mem_addr_o, mem_wdata_o});
                        mem[mem_addr_o] = mem_wdata_o;
                    end else begin
                        n_rd_obs++; rd_a = mem_addr_o; rd_addr_obs = mem_addr_o;
                        rd_pend = 1; rv_wait = 0;
                    end
                end else begin
                    ph_wait++;
                end
            end
            if (req_ready_o) ready_bad = 1;
            if (done_o) begin
                obs_rsp.push_back(rsp_t'{err_o, 8'(k)});
                done = 1; req_valid_i = 1'b0;
            end
            prev_req = mem_req_o & ~mem_gnt_i;
            prev_addr = mem_addr_o; prev_we = mem_we_o; prev_wdata = mem_wdata_o;
            @(posedge clk_i); #1;
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; req_valid_i = 1'b0;
        if (!done) begin
            $display("FAIL timeout: no done_o within 40 cycles (addr %h)", a);
            obs_rsp.push_back(rsp_t'{1'bx, 8'hFF});
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; req_valid_i = 1'b1; req_addr_i = 32'h10; req_data_i = '1; req_size_i = 2'b10;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = '1;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({req_ready_o, done_o, err_o, mem_req_o, mem_we_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/done/err/req/we=%b expected 00000",
                     {req_ready_o, done_o, err_o, mem_req_o, mem_we_o});
        end
        n_cmp++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h wdata=%h expected 0/0", mem_addr_o, mem_wdata_o);
        end
        req_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        n_cmp++;
        if (req_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b req=%b expected 1/0", req_ready_o, mem_req_o);
        end
    endtask

    task automatic check_results(input string name, input int exp_reads);
        wr_t  ew, ow;
        rsp_t er, orr;
        while (exp_wr.size() != 0) begin
            ew = exp_wr.pop_front();
            ow = (obs_wr.size() != 0) ? obs_wr.pop_front() : wr_t'{32'hx, 32'hx};
            n_cmp++;
            if (ow !== ew) begin
                n_fail++;
                $display("FAIL %s_write: got addr=%h data=%h expected addr=%h data=%h",
                         name, ow.addr, ow.data, ew.addr, ew.data);
            end
        end
        n_cmp++;
        if (obs_wr.size() != 0) begin
            n_fail++;
            $display("FAIL %s_extra_write: got %0d extra writes expected 0", name, obs_wr.size());
            obs_wr.delete();
        end
        while (exp_rsp.size() != 0) begin
            er  = exp_rsp.pop_front();
            orr = (obs_rsp.size() != 0) ? obs_rsp.pop_front() : rsp_t'{1'bx, 8'hFF};
            n_cmp++;
            if (orr !== er) begin
                n_fail++;
                $display("FAIL %s_resp: got err=%b lat=%0d expected err=%b lat=%0d",
                         name, orr.err, orr.lat, er.err, er.lat);
            end
        end
        obs_rsp.delete();
        n_cmp++;
        if (n_rd_obs != exp_reads || ready_at_acc !== 1'b1 || ready_bad) begin
            n_fail++;
            $display("FAIL %s_reads_ready: got reads=%0d acc_ready=%b busy_ready=%b expected %0d/1/0",
                     name, n_rd_obs, ready_at_acc, ready_bad, exp_reads);
        end
    endtask

    task automatic test_word();
        exp_wr.push_back(wr_t'{32'h10, 32'hDEAD_BEEF});
        exp_rsp.push_back(rsp_t'{1'b0, 8'd2});
        do_store(32'h10, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0);
        check_results("word", 0);
    endtask

    task automatic test_byte();
        mem[32'h20] = 32'h1122_3344;
        exp_wr.push_back(wr_t'{32'h20, 32'h11AB_3344});
        exp_rsp.push_back(rsp_t'{1'b0, 8'd4});
        do_store(32'h22, 32'h0000_00AB, 2'b00, 0, 0, 0, 0);
        n_cmp++;
        if (rd_addr_obs !== 32'h20) begin
            n_fail++;
            $display("FAIL byte_read_addr: got %h expected 00000020", rd_addr_obs);
        end
        // Upper data bits must be ignored for a byte store in the top lane.
        exp_wr.push_back(wr_t'{32'h20, 32'h5AAB_3344});
        exp_rsp.push_back(rsp_t'{1'b0, 8'd4});
        do_store(32'h23, 32'hFFFF_FF5A, 2'b00, 0, 0, 0, 0);
        check_results("byte", 1);
    endtask

    task automatic test_half();
        mem[32'h30] = 32'h5566_7788;
        exp_wr.push_back(wr_t'{32'h30, 32'hCAFE_7788});
        exp_rsp.push_back(rsp_t'{1'b0, 8'd4});
        do_store(32'h32, 32'h0000_CAFE, 2'b01, 0, 0, 0, 0);
        check_results("half_hi", 1);
        exp_wr.push_back(wr_t'{32'h30, 32'hCAFE_1234});
        exp_rsp.push_back(rsp_t'{1'b0, 8'd4});
        do_store(32'h30, 32'hABCD_1234, 2'b01, 0, 0, 0, 0);
        check_results("half_lo", 1);
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = 32'h41; sizes[0] = 2'b01;
        addrs[1] = 32'h42; sizes[1] = 2'b10;
        addrs[2] = 32'h40; sizes[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            exp_rsp.push_back(rsp_t'{1'b1, 8'd1});
            do_store(addrs[i], 32'h1234_5678, sizes[i], 0, 0, 0, 0);
            n_cmp++;
            if (any_req) begin
                n_fail++;
                $display("FAIL err_no_traffic[%0d]: got mem_req_o asserted expected never", i);
            end
            check_results("err", 0);
        end
    endtask

    task automatic test_backpressure();
        bit stray;
        mem[32'h20] = 32'hA1B2_C3D4;
        exp_wr.push_back(wr_t'{32'h20, 32'hA1B2_77D4});
        exp_rsp.push_back(rsp_t'{1'b0, 8'd11});
        do_store(32'h21, 32'h0000_0077, 2'b00, 3, 2, 2, 1);
        n_cmp++;
        if (unstable) begin
            n_fail++;
            $display("FAIL bp_stable: got request changing while stalled expected stable");
        end
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_req_o || done_o) stray = 1;
            @(posedge clk_i); #1;
        end
        n_cmp++;
        if (stray || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_second: got stray=%b ready=%b expected 0/1", stray, req_ready_o);
        end
        check_results("bp", 1);
    endtask

    task automatic test_reset_mid();
        bit stray;
        mem[32'h50] = 32'h0102_0304;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_addr_i = 32'h51; req_data_i = 32'hEE; req_size_i = 2'b00;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n_cmp++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h50) begin
            n_fail++;
            $display("FAIL rm_read: got req=%b we=%b addr=%h expected 1/0/00000050",
                     mem_req_o, mem_we_o, mem_addr_o);
        end
        mem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b0;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready_o, done_o, err_o, mem_req_o, mem_we_o} !== 5'b0 ||
            mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_outputs_in_reset: got ctrl=%b addr=%h wdata=%h expected all 0",
                     {req_ready_o, done_o, err_o, mem_req_o, mem_we_o}, mem_addr_o, mem_wdata_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = mem[32'h50];
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            if (mem_req_o || done_o) stray = 1;
            @(posedge clk_i); #1;
            mem_rvalid_i = 1'b0;
        end
        n_cmp++;
        if (stray) begin
            n_fail++;
            $display("FAIL rm_no_write: got memory request or done after reset expected none");
        end
        exp_wr.push_back(wr_t'{32'h54, 32'hCAFE_F00D});
        exp_rsp.push_back(rsp_t'{1'b0, 8'd2});
        do_store(32'h54, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 0);
        check_results("rm_word", 0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
